// File: rtl/axi_wr_i2c_sequencer.sv
// AXI write-slave front end of the AXI-to-I2C bridge: each AXI write burst becomes one I2C
// write transaction (address byte, then data bytes LSB first) over a byte command handshake.
module axi_wr_i2c_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SIZE           = 3,
    parameter int BURST_SIZE     = 2,
    parameter int RESPONSE_WIDTH = 2
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic [SIZE-1:0]           AWSIZE,
    input  logic [BURST_SIZE-1:0]     AWBURST,
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic                      WLAST,
    input  logic [DATA_WIDTH-1:0]     WADATA,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic [RESPONSE_WIDTH-1:0] BRESP,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [7:0]                cmd_byte,
    output logic                      cmd_start,
    output logic                      cmd_stop,
    input  logic                      i2c_done,
    input  logic                      i2c_nack
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_LOAD      = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_DRAIN     = 3'd5;
    localparam logic [2:0] ST_RESP      = 3'd6;

    localparam logic [8:0]                BUS_BYTES  = 9'(DATA_WIDTH / 8);
    localparam logic [BURST_SIZE-1:0]     BURST_WRAP = BURST_SIZE'(2'b10);
    localparam logic [RESPONSE_WIDTH-1:0] RESP_OKAY  = RESPONSE_WIDTH'(2'b00);
    localparam logic [RESPONSE_WIDTH-1:0] RESP_SLV   = RESPONSE_WIDTH'(2'b10);

    logic [2:0]                state_r, next_state_s;
    logic [6:0]                addr_r, next_addr_s;
    logic [SIZE-1:0]           size_r, next_size_s;
    logic [DATA_WIDTH-1:0]     beat_r, next_beat_s;
    logic                      last_r, next_last_s;
    logic [7:0]                idx_r, next_idx_s;
    logic [RESPONSE_WIDTH-1:0] bresp_r, next_bresp_s;

    logic                  awready_r, wready_r, bvalid_r;
    logic                  cmd_valid_r, cmd_start_r, cmd_stop_r;
    logic [7:0]            cmd_byte_r;
    logic                  awready_s, wready_s, bvalid_s;
    logic                  cmd_valid_s, cmd_start_s, cmd_stop_s;
    logic [7:0]            cmd_byte_s;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic                  unused_s;

    assign unused_s = ^AWADDR[ADDR_WIDTH-1:7];

    function automatic logic [8:0] beat_bytes(input logic [SIZE-1:0] sz);
        return 9'd1 << sz;
    endfunction

    function automatic logic [7:0] last_index(input logic [SIZE-1:0] sz);
        return 8'(beat_bytes(sz) - 9'd1);
    endfunction

    // Next-state and datapath update for the burst sequencing FSM
    always_comb begin
        next_state_s = state_r;
        next_addr_s  = addr_r;
        next_size_s  = size_r;
        next_beat_s  = beat_r;
        next_last_s  = last_r;
        next_idx_s   = idx_r;
        next_bresp_s = bresp_r;
        case (state_r)
            ST_IDLE: begin
                if (AWVALID && awready_r) begin
                    next_addr_s = AWADDR[6:0];
                    next_size_s = AWSIZE;
                    // Unsupported bursts are drained and answered with SLVERR
                    if ((AWBURST == BURST_WRAP) || (beat_bytes(AWSIZE) > BUS_BYTES)) begin
                        next_state_s = ST_DRAIN;
                    end else begin
                        next_state_s = ST_ADDR;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (cmd_ready) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_ADDR;
                end
            end
            ST_LOAD: begin
                if (WVALID && wready_r) begin
                    next_beat_s  = WADATA;
                    next_last_s  = WLAST;
                    next_idx_s   = 8'd0;
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_DATA: begin
                if (cmd_ready && (idx_r == last_index(size_r))) begin
                    next_state_s = last_r ? ST_WAIT_DONE : ST_LOAD;
                end else if (cmd_ready) begin
                    next_idx_s = idx_r + 8'd1;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_WAIT_DONE: begin
                if (i2c_done) begin
                    next_bresp_s = i2c_nack ? RESP_SLV : RESP_OKAY;
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT_DONE;
                end
            end
            ST_DRAIN: begin
                if (WVALID && wready_r && WLAST) begin
                    next_bresp_s = RESP_SLV;
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_RESP: begin
                if (BREADY && bvalid_r) begin
                    next_bresp_s = RESP_OKAY;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_bresp_s = RESP_OKAY;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every port comes straight from a flop
    always_comb begin
        awready_s   = (next_state_s == ST_IDLE);
        wready_s    = (next_state_s == ST_LOAD) || (next_state_s == ST_DRAIN);
        bvalid_s    = (next_state_s == ST_RESP);
        cmd_valid_s = (next_state_s == ST_ADDR) || (next_state_s == ST_DATA);
        cmd_start_s = (next_state_s == ST_ADDR);
        shifted_s   = next_beat_s >> {next_idx_s, 3'b000};
        if (next_state_s == ST_ADDR) begin
            cmd_byte_s = {next_addr_s, 1'b0};
            cmd_stop_s = 1'b0;
        end else if (next_state_s == ST_DATA) begin
            cmd_byte_s = shifted_s[7:0];
            cmd_stop_s = next_last_s && (next_idx_s == last_index(next_size_s));
        end else begin
            cmd_byte_s = 8'd0;
            cmd_stop_s = 1'b0;
        end
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r     <= ST_IDLE;
            addr_r      <= 7'd0;
            size_r      <= '0;
            beat_r      <= '0;
            last_r      <= 1'b0;
            idx_r       <= 8'd0;
            bresp_r     <= '0;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            cmd_valid_r <= 1'b0;
            cmd_start_r <= 1'b0;
            cmd_stop_r  <= 1'b0;
            cmd_byte_r  <= 8'd0;
        end else begin
            state_r     <= next_state_s;
            addr_r      <= next_addr_s;
            size_r      <= next_size_s;
            beat_r      <= next_beat_s;
            last_r      <= next_last_s;
            idx_r       <= next_idx_s;
            bresp_r     <= next_bresp_s;
            awready_r   <= awready_s;
            wready_r    <= wready_s;
            bvalid_r    <= bvalid_s;
            cmd_valid_r <= cmd_valid_s;
            cmd_start_r <= cmd_start_s;
            cmd_stop_r  <= cmd_stop_s;
            cmd_byte_r  <= cmd_byte_s;
        end
    end

    assign AWREADY   = awready_r;
    assign WREADY    = wready_r;
    assign BVALID    = bvalid_r;
    assign BRESP     = bresp_r;
    assign cmd_valid = cmd_valid_r;
    assign cmd_byte  = cmd_byte_r;
    assign cmd_start = cmd_start_r;
    assign cmd_stop  = cmd_stop_r;

endmodule
